// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_SLL = 4'h0;
  localparam logic [3:0] OP_ROL = 4'h1;
  localparam logic [3:0] OP_SRL = 4'h2;
  localparam logic [3:0] OP_SRA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_INC = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_DEC = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_XOR = 4'hA;
  localparam logic [3:0] OP_NOR = 4'hB;
  localparam logic [3:0] OP_EQ  = 4'hC;
  localparam logic [3:0] OP_NE  = 4'hD;
  localparam logic [3:0] OP_GT  = 4'hE;
  localparam logic [3:0] OP_LT  = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

endpackage

// File: rtl/alu_seq_addsub.sv
// WIDTH-bit adder/subtractor; subtract is A + ~B + 1, so carry-out 1 means no borrow.
module alu_seq_addsub
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c,
  output logic             o_v
);

  logic [WIDTH-1:0] w_b;

  assign w_b = i_sub ? ~i_b : i_b;
  assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
  // Overflow: both effective operands share a sign that the sum does not.
  assign o_v = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; shifts take one cycle per bit position.
// Define ALU_SEQ_CMP_EN to build the comparator opcodes (otherwise they return zero).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n
);

  localparam int SHW = $clog2(WIDTH);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sh, r_result;
  logic [3:0]       r_op;
  logic [SHW-1:0]   r_cnt;
  logic             r_sc, r_z, r_c, r_v, r_n;

  logic             w_accept;
  logic [SHW-1:0]   w_k;
  logic [WIDTH-1:0] w_sh_nxt, w_as_b, w_sum, w_res;
  logic             w_sc_nxt, w_cout, w_ovf, w_c, w_v;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_k       = op_a[SHW-1:0];

  assign result = r_result;
  assign flag_z = r_z;
  assign flag_c = r_c;
  assign flag_v = r_v;
  assign flag_n = r_n;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Shifts spend k cycles in SHIFT, then pass through EXEC to register the result.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (is_shift(opcode) && (w_k != '0)) ? S_SHIFT : S_EXEC;
      S_SHIFT: if (r_cnt == SHW'(1)) w_next = S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sh_nxt = r_sh;
    w_sc_nxt = 1'b0;
    case (r_op[1:0])
      2'b00: {w_sc_nxt, w_sh_nxt} = {r_sh, 1'b0};
      2'b01: w_sh_nxt = {r_sh[WIDTH-2:0], r_sh[WIDTH-1]};
      2'b10: {w_sh_nxt, w_sc_nxt} = {1'b0, r_sh};
      default: {w_sh_nxt, w_sc_nxt} = {r_sh[WIDTH-1], r_sh};
    endcase
  end

  // INC/DEC share the adder with B forced to 1; op[1] selects subtract.
  assign w_as_b = r_op[0] ? WIDTH'(1) : r_b;

  alu_seq_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a   (r_a),
    .i_b   (w_as_b),
    .i_sub (r_op[1]),
    .o_sum (w_sum),
    .o_c   (w_cout),
    .o_v   (w_ovf)
  );

`ifdef ALU_SEQ_CMP_EN
  logic w_cmp;
  always_comb begin
    case (r_op[1:0])
      2'b00:   w_cmp = (r_a == r_b);
      2'b01:   w_cmp = (r_a != r_b);
      2'b10:   w_cmp = ($signed(r_a) > $signed(r_b));
      default: w_cmp = ($signed(r_a) < $signed(r_b));
    endcase
  end
`endif

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_SLL, OP_ROL, OP_SRL, OP_SRA: begin
        w_res = r_sh;
        w_c   = r_sc;
      end
      OP_ADD, OP_INC, OP_SUB, OP_DEC: begin
        w_res = w_sum;
        w_c   = w_cout;
        w_v   = w_ovf;
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOR: w_res = ~(r_a | r_b);
`ifdef ALU_SEQ_CMP_EN
      default: w_res = {{(WIDTH-1){1'b0}}, w_cmp};
`else
      default: w_res = '0;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_sc     <= 1'b0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_n      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= op_a;
        r_b   <= op_b;
        r_sh  <= op_b;
        r_op  <= opcode;
        r_cnt <= w_k;
        r_sc  <= 1'b0;
      end
      if (r_state == S_SHIFT) begin
        r_sh  <= w_sh_nxt;
        r_sc  <= w_sc_nxt;
        r_cnt <= r_cnt - SHW'(1);
      end
      if (r_state == S_EXEC) begin
        r_result <= w_res;
        r_z      <= (w_res == '0);
        r_n      <= w_res[WIDTH-1];
        r_c      <= w_c;
        r_v      <= w_v;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; expected values worked out by hand.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [3:0]   opcode = '0;
  logic         in_ready, out_valid, flag_z, flag_c, flag_v, flag_n;
  logic [W-1:0] result;

  int n_chk  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_n    (flag_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags();
    return {flag_z, flag_c, flag_v, flag_n};
  endfunction

  // Flags are packed {Z,C,V,N}. Junk operands are driven while busy and must be ignored.
  task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input int lat, input logic [7:0] er,
                     input logic [3:0] ef, input int hold);
    int n;
    int bad;
    chk({tag, "_rdy"}, 32'(in_ready), 32'(1));
    opcode = op; op_a = a; op_b = b; in_valid = 1'b1;
    step();
    op_a = ~a; op_b = ~b; opcode = ~op;
    n = 0; bad = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) bad++;
      step();
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_flg"}, 32'(flags()), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      step();
      if (!out_valid || result !== er || flags() !== ef || in_ready) bad++;
    end
    chk({tag, "_busy"}, 32'(bad), 32'(0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ret"}, 32'({out_valid, in_ready}), 32'(2'b01));
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    step();
    step();
    chk("rst_hs", 32'({out_valid, in_ready}), 32'(0));
    chk("rst_res", 32'({result, flags()}), 32'(0));
    rst = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready), 32'(1));

    run("add_ovf", 4'h4, 8'h7F, 8'h01, 1, 8'h80, 4'b0011, 0);
    run("sub_eq",  4'h6, 8'h05, 8'h05, 1, 8'h00, 4'b1100, 0);
    run("sra3",    4'h3, 8'h03, 8'h80, 4, 8'hF0, 4'b0001, 0);
    run("sll1",    4'h0, 8'h01, 8'h81, 2, 8'h02, 4'b0100, 0);
    run("rol4",    4'h1, 8'h04, 8'h81, 5, 8'h18, 4'b0000, 0);
    run("srl2",    4'h2, 8'h02, 8'h03, 3, 8'h00, 4'b1100, 0);
    run("srl7",    4'h2, 8'h07, 8'h80, 8, 8'h01, 4'b0000, 0);
    run("sll0",    4'h0, 8'h08, 8'hA5, 1, 8'hA5, 4'b0001, 0);
    run("inc_wrap",4'h5, 8'hFF, 8'h33, 1, 8'h00, 4'b1100, 0);
    run("dec_ovf", 4'h7, 8'h80, 8'h33, 1, 8'h7F, 4'b0110, 0);
    run("sub_brw", 4'h6, 8'h00, 8'h01, 1, 8'hFF, 4'b0001, 0);
    run("and",     4'h8, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000, 0);
    run("or",      4'h9, 8'h50, 8'h0A, 1, 8'h5A, 4'b0000, 0);
    run("xor",     4'hA, 8'hAA, 8'h0F, 1, 8'hA5, 4'b0001, 0);
    run("nor",     4'hB, 8'h0F, 8'hF0, 1, 8'h00, 4'b1000, 0);
`ifdef ALU_SEQ_CMP_EN
    run("gt",      4'hE, 8'h01, 8'hFF, 1, 8'h01, 4'b0000, 0);
    run("eq",      4'hC, 8'h05, 8'h05, 1, 8'h01, 4'b0000, 0);
    run("ne",      4'hD, 8'h05, 8'h05, 1, 8'h00, 4'b1000, 0);
    run("lt",      4'hF, 8'h80, 8'h01, 1, 8'h01, 4'b0000, 0);
`else
    run("gt",      4'hE, 8'h01, 8'hFF, 1, 8'h00, 4'b1000, 0);
    run("eq",      4'hC, 8'h05, 8'h05, 1, 8'h00, 4'b1000, 0);
    run("lt",      4'hF, 8'h80, 8'h01, 1, 8'h00, 4'b1000, 0);
`endif
    run("hold",    4'h4, 8'h12, 8'h34, 1, 8'h46, 4'b0000, 5);

    // Reset on the second shift cycle of a 5-step SLL.
    opcode = 4'h0; op_a = 8'h05; op_b = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("abort_rdy_rst", 32'(in_ready), 32'(0));
    step();
    rst = 1'b0;
    #1;
    chk("abort_out", 32'({out_valid, result, flags()}), 32'(0));
    chk("abort_rdy", 32'(in_ready), 32'(1));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) bad++;
    end
    chk("abort_noval", 32'(bad), 32'(0));

    // Reset while a result is pending in DONE.
    opcode = 4'h4; op_a = 8'h21; op_b = 8'h21; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("done_pre", 32'({out_valid, result}), 32'({1'b1, 8'h42}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("done_rst", 32'({out_valid, result, flags()}), 32'(0));
    chk("done_rdy", 32'(in_ready), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
